// File: rtl/buf_exec_scheduler.sv
// Segment scheduler for the command-buffer executor.
// Queues segment start addresses, launches them in order, tracks status.
module buf_exec_scheduler #(
    parameter int QDEPTH_LOG2 = 3,
    parameter bit ERR_STOP    = 1'b1,
    parameter int WDOG_W      = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   q_push,
    input  logic [15:0]            q_addr,
    input  logic                   q_flush,
    output logic [QDEPTH_LOG2:0]   q_level,
    output logic                   q_full,
    output logic                   q_empty,
    output logic                   q_overflow,
    input  logic                   run_enable,
    input  logic                   host_abort,
    input  logic                   halt_clear,
    input  logic [WDOG_W-1:0]      wdog_limit,
    output logic                   exec_start,
    output logic [15:0]            exec_start_addr,
    output logic                   exec_abort,
    input  logic                   exec_complete,
    input  logic [7:0]             exec_error,
    output logic                   busy,
    output logic                   halted,
    output logic [15:0]            last_addr,
    output logic [7:0]             last_error,
    output logic [15:0]            done_count
);

    localparam int DEPTH = 1 << QDEPTH_LOG2;
    localparam int LW    = QDEPTH_LOG2 + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [7:0] ERR_HOST = 8'h82;
    localparam logic [7:0] ERR_WDOG = 8'h83;

    logic [15:0]            mem [DEPTH];
    logic [QDEPTH_LOG2-1:0] wr_ptr;
    logic [QDEPTH_LOG2-1:0] rd_ptr;
    logic [15:0]            head;
    logic [LW-1:0]          level_n;

    logic [1:0]        state;
    logic [1:0]        state_n;
    logic [WDOG_W-1:0] wdog;

    logic push_ok;
    logic pop;
    logic abort_n;
    logic cmpl;
    logic wdog_hit;
    logic host_kill;

    assign head      = mem[rd_ptr];
    assign push_ok   = q_push & ~q_full & ~q_flush;
    assign host_kill = host_abort & (state != S_HALT);

    // Next-state decode; host abort overrides all per-state handling.
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        abort_n  = 1'b0;
        cmpl     = 1'b0;
        wdog_hit = 1'b0;
        if (host_kill) begin
            state_n = S_HALT;
            abort_n = 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run_enable && !q_empty && !q_flush) begin
                        pop     = 1'b1;
                        state_n = S_START;
                    end
                end
                S_START: begin
                    state_n = S_RUN;
                end
                S_RUN: begin
                    if (exec_complete) begin
                        cmpl = 1'b1;
                        if (ERR_STOP && exec_error != 8'h00)
                            state_n = S_HALT;
                        else
                            state_n = S_IDLE;
                    end else if (wdog_limit != '0 &&
                                 wdog == wdog_limit) begin
                        wdog_hit = 1'b1;
                        abort_n  = 1'b1;
                        state_n  = S_HALT;
                    end
                end
                S_HALT: begin
                    if (halt_clear)
                        state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // Queue occupancy after this cycle's flush/push/pop.
    always_comb begin
        level_n = q_level;
        if (q_flush)
            level_n = '0;
        else if (push_ok && !pop)
            level_n = q_level + 1'b1;
        else if (pop && !push_ok)
            level_n = q_level - 1'b1;
    end

    // Queue storage; entries need no reset, occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= q_addr;
    end

    // Queue pointers, level and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_level    <= '0;
            q_full     <= 1'b0;
            q_empty    <= 1'b1;
            q_overflow <= 1'b0;
        end else begin
            q_level <= level_n;
            q_full  <= (level_n == LVL_FULL);
            q_empty <= (level_n == '0);
            if (q_flush) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                q_overflow <= 1'b0;
            end else begin
                if (push_ok)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (q_push && q_full)
                    q_overflow <= 1'b1;
            end
        end
    end

    // Watchdog counts cycles already spent in S_RUN.
    always_ff @(posedge clk) begin
        if (rst)
            wdog <= '0;
        else if (state == S_START)
            wdog <= '0;
        else if (state == S_RUN)
            wdog <= wdog + 1'b1;
    end

    // State register and registered status/control outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            exec_start      <= 1'b0;
            exec_abort      <= 1'b0;
            exec_start_addr <= '0;
            busy            <= 1'b0;
            halted          <= 1'b0;
            last_addr       <= '0;
            last_error      <= '0;
            done_count      <= '0;
        end else begin
            state      <= state_n;
            exec_start <= (state_n == S_START);
            exec_abort <= abort_n;
            busy       <= (state_n == S_START) |
                          (state_n == S_RUN);
            halted     <= (state_n == S_HALT);
            if (pop) begin
                exec_start_addr <= head;
                last_addr       <= head;
            end
            if (cmpl) begin
                done_count <= done_count + 1'b1;
                last_error <= exec_error;
            end
            if (host_kill)
                last_error <= ERR_HOST;
            else if (wdog_hit)
                last_error <= ERR_WDOG;
        end
    end

endmodule

// File: tb/tb_buf_exec_scheduler.sv
// Directed bench for buf_exec_scheduler.
// Queue table vectors plus hand sequences for multi-cycle cases.
module tb_buf_exec_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        q_push;
    logic [15:0] q_addr;
    logic        q_flush;
    logic [3:0]  q_level;
    logic        q_full;
    logic        q_empty;
    logic        q_overflow;
    logic        run_enable;
    logic        host_abort;
    logic        halt_clear;
    logic [23:0] wdog_limit;
    logic        exec_start;
    logic [15:0] exec_start_addr;
    logic        exec_abort;
    logic        exec_complete;
    logic [7:0]  exec_error;
    logic        busy;
    logic        halted;
    logic [15:0] last_addr;
    logic [7:0]  last_error;
    logic [15:0] done_count;

    buf_exec_scheduler #(
        .QDEPTH_LOG2(3),
        .ERR_STOP(1'b1),
        .WDOG_W(24)
    ) dut (
        .clk(clk),
        .rst(rst),
        .q_push(q_push),
        .q_addr(q_addr),
        .q_flush(q_flush),
        .q_level(q_level),
        .q_full(q_full),
        .q_empty(q_empty),
        .q_overflow(q_overflow),
        .run_enable(run_enable),
        .host_abort(host_abort),
        .halt_clear(halt_clear),
        .wdog_limit(wdog_limit),
        .exec_start(exec_start),
        .exec_start_addr(exec_start_addr),
        .exec_abort(exec_abort),
        .exec_complete(exec_complete),
        .exec_error(exec_error),
        .busy(busy),
        .halted(halted),
        .last_addr(last_addr),
        .last_error(last_error),
        .done_count(done_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic [15:0] addr;
        logic        flush;
        logic        run;
        logic [3:0]  lvl;
        logic        full;
        logic        empty;
        logic        ov;
    } vec_t;

    vec_t        tbl [14];
    int          n_pass  = 0;
    int          n_total = 0;
    logic [15:0] exp_done = 16'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic push(input logic [15:0] a);
        q_push = 1'b1;
        q_addr = a;
        step();
        q_push = 1'b0;
    endtask

    task automatic check_reset(input string p);
        check({p, "_start"}, exec_start, 0);
        check({p, "_abort"}, exec_abort, 0);
        check({p, "_busy"}, busy, 0);
        check({p, "_halted"}, halted, 0);
        check({p, "_ovf"}, q_overflow, 0);
        check({p, "_saddr"}, exec_start_addr, 0);
        check({p, "_laddr"}, last_addr, 0);
        check({p, "_done"}, done_count, 0);
        check({p, "_lerr"}, last_error, 0);
        check({p, "_level"}, q_level, 0);
        check({p, "_empty"}, q_empty, 1);
        check({p, "_full"}, q_full, 0);
    endtask

    task automatic wait_start();
        for (int i = 0; i < 20 && !exec_start; i++)
            step();
        check("start_seen", exec_start, 1);
    endtask

    task automatic run_segment(input logic [15:0] a,
                               input logic [7:0] e);
        wait_start();
        check("start_addr", exec_start_addr, a);
        step();
        step();
        exec_complete = 1'b1;
        exec_error    = e;
        step();
        exec_complete = 1'b0;
        exec_error    = 8'h00;
        exp_done      = exp_done + 16'd1;
        check("seg_done", done_count, exp_done);
        check("seg_lerr", last_error, e);
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            q_push     = tbl[i].push;
            q_addr     = tbl[i].addr;
            q_flush    = tbl[i].flush;
            run_enable = tbl[i].run;
            step();
            check($sformatf("row%0d_lvl", i), q_level, tbl[i].lvl);
            check($sformatf("row%0d_full", i), q_full, tbl[i].full);
            check($sformatf("row%0d_empty", i), q_empty, tbl[i].empty);
            check($sformatf("row%0d_ovf", i), q_overflow, tbl[i].ov);
        end
        q_push  = 1'b0;
        q_flush = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        int n;
        for (int i = 0; i < 8; i++)
            tbl[i] = '{1'b1, 16'h1100 + 16'(i), 1'b0, 1'b0,
                       4'(i + 1), (i == 7), 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 16'h1FFF, 1'b0, 1'b0, 4'd8, 1'b1, 1'b0, 1'b1};
        tbl[9]  = '{1'b1, 16'h0AAA, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 16'h0BBB, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 16'h0CCC, 1'b0, 1'b0, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 16'h0DDD, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};

        rst           = 1'b1;
        q_push        = 1'b0;
        q_addr        = 16'h0;
        q_flush       = 1'b0;
        run_enable    = 1'b0;
        host_abort    = 1'b0;
        halt_clear    = 1'b0;
        wdog_limit    = 24'd0;
        exec_complete = 1'b0;
        exec_error    = 8'h00;
        step();
        step();
        check_reset("rst");
        rst = 1'b0;
        step();

        // two clean segments in order
        push(16'h0010);
        push(16'h0040);
        run_enable = 1'b1;
        run_segment(16'h0010, 8'h00);
        run_segment(16'h0040, 8'h00);
        step();
        check("t1_done", done_count, 16'd2);
        check("t1_empty", q_empty, 1);
        check("t1_busy", busy, 0);
        check("t1_halted", halted, 0);
        check("t1_laddr", last_addr, 16'h0040);
        run_enable = 1'b0;
        step();

        // error completion halts with one entry still queued
        push(16'h0200);
        push(16'h0300);
        run_enable = 1'b1;
        run_segment(16'h0200, 8'h05);
        check("t2_halted", halted, 1);
        check("t2_busy", busy, 0);
        check("t2_level", q_level, 4'd1);
        step();
        step();
        step();
        check("t2_no_start", exec_start, 0);
        check("t2_still_halt", halted, 1);
        halt_clear = 1'b1;
        step();
        halt_clear = 1'b0;
        check("t2_cleared", halted, 0);
        run_segment(16'h0300, 8'h00);
        run_enable = 1'b0;
        step();

        // watchdog expiry without completion
        wdog_limit = 24'd20;
        push(16'h0500);
        run_enable = 1'b1;
        wait_start();
        n = 0;
        for (int i = 0; i < 40 && !exec_abort; i++) begin
            step();
            n++;
        end
        check("t3_wdog_cycles", n, 22);
        check("t3_abort", exec_abort, 1);
        check("t3_halted", halted, 1);
        check("t3_lerr", last_error, 8'h83);
        check("t3_done", done_count, exp_done);
        run_enable = 1'b0;
        step();
        check("t3_abort_pulse", exec_abort, 0);
        halt_clear = 1'b1;
        step();
        halt_clear = 1'b0;

        // completion on the watchdog limit cycle wins
        wdog_limit = 24'd3;
        push(16'h0510);
        run_enable = 1'b1;
        wait_start();
        step();
        step();
        step();
        step();
        exec_complete = 1'b1;
        step();
        exec_complete = 1'b0;
        exp_done      = exp_done + 16'd1;
        check("t3b_abort", exec_abort, 0);
        check("t3b_halted", halted, 0);
        check("t3b_done", done_count, exp_done);
        check("t3b_lerr", last_error, 8'h00);
        run_enable = 1'b0;
        wdog_limit = 24'd0;
        step();
        check("t3b_late_abort", exec_abort, 0);

        // fill, overflow, wrap-around drain, flush
        apply_rows(0, 8);
        run_enable = 1'b1;
        q_push     = 1'b1;
        q_addr     = 16'h0EEE;
        step();
        q_push = 1'b0;
        check("t4_full_pp_lvl", q_level, 4'd7);
        check("t4_full_pp_ovf", q_overflow, 1);
        for (int i = 0; i < 8; i++)
            run_segment(16'h1100 + 16'(i), 8'h00);
        run_enable = 1'b0;
        step();
        check("t4_drain_empty", q_empty, 1);
        check("t4_drain_ovf", q_overflow, 1);
        check("t4_drain_busy", busy, 0);
        apply_rows(9, 13);
        check("t4_run_busy", busy, 1);
        check("t4_run_abort", exec_abort, 0);
        check("t4_run_saddr", exec_start_addr, 16'h0CCC);
        check("t4_run_laddr", last_addr, 16'h0CCC);
        step();
        exec_complete = 1'b1;
        step();
        exec_complete = 1'b0;
        exp_done      = exp_done + 16'd1;
        check("t4_fin_done", done_count, exp_done);
        check("t4_fin_busy", busy, 0);
        step();
        check("t4_fin_nostart", exec_start, 0);

        // host abort with simultaneous completion
        push(16'h0600);
        run_enable = 1'b1;
        wait_start();
        step();
        step();
        host_abort    = 1'b1;
        exec_complete = 1'b1;
        exec_error    = 8'h11;
        step();
        host_abort    = 1'b0;
        exec_complete = 1'b0;
        exec_error    = 8'h00;
        check("t5_abort", exec_abort, 1);
        check("t5_halted", halted, 1);
        check("t5_lerr", last_error, 8'h82);
        check("t5_done", done_count, exp_done);
        step();
        check("t5_abort_pulse", exec_abort, 0);
        host_abort = 1'b1;
        step();
        host_abort = 1'b0;
        check("t5_halt_ign", exec_abort, 0);
        check("t5_halt_lerr", last_error, 8'h82);
        run_enable = 1'b0;
        halt_clear = 1'b1;
        step();
        halt_clear = 1'b0;
        check("t5_cleared", halted, 0);

        // reset while running
        push(16'h0700);
        push(16'h0710);
        run_enable = 1'b1;
        wait_start();
        step();
        step();
        check("t6_pre_busy", busy, 1);
        rst = 1'b1;
        step();
        check_reset("t6");
        rst        = 1'b0;
        run_enable = 1'b0;
        step();
        check("t6_post_abort", exec_abort, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
